adc_capture: RTL and testbench
==============================

# adc_capture

Triggered capture buffer for the dual-channel 12-bit ADC path. It sits beside the ADC→DAC loopback and taps the same single-clock-domain ADC samples. On a trigger it records a programmable number of optionally decimated sample pairs into on-chip RAM. The SoC side then reads the pairs back through a simple addressed read port.

## Interface
Parameters:
- DEPTH_LOG2, 10: log2 of buffer depth in sample pairs (DEPTH = 2**DEPTH_LOG2).
- DATA_W, 12: ADC sample width, unsigned offset-binary.

Ports:
- sys_clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of sys_clk.
- adc_ch0  in  DATA_W  channel 0 sample, new value every cycle.
- adc_ch1  in  DATA_W  channel 1 sample.
- arm  in  1  one-cycle pulse: start waiting for trigger.
- abort  in  1  one-cycle pulse: return to IDLE.
- sw_trig  in  1  software trigger pulse.
- trig_sel  in  1  0 = software trigger only; 1 = also level trigger on ch0.
- threshold  in  DATA_W  level-trigger threshold.
- decim  in  8  store one pair every decim+1 cycles.
- cap_len  in  DEPTH_LOG2  pairs to capture; 0 means DEPTH.
- rd_en  in  1  read request.
- rd_addr  in  DEPTH_LOG2  read address.
- rd_data  out  2*DATA_W  {ch1, ch0}.
- rd_valid  out  1  rd_data valid.
- busy  out  1  state is ARMED or CAPTURE.
- done  out  1  capture complete; held until arm or abort.
- wr_count  out  DEPTH_LOG2+1  pairs written in the current or last capture.

## Operation
- Both ADC inputs are registered once into s0/s1. All trigger logic and all writes use s0/s1.
- The FSM has four states: IDLE, ARMED, CAPTURE, DONE.
- arm in IDLE or DONE moves to ARMED. It clears done and wr_count. arm in ARMED or CAPTURE is ignored.
- Trigger condition in ARMED is either of:
  - sw_trig=1.
  - trig_sel=1, the level trigger is compiled in, and prev_s0 < threshold ≤ s0 (unsigned rising crossing). prev_s0 is s0 delayed one cycle.
- On trigger, the current {s1,s0} is written to address 0, wr_count becomes 1 and dec_cnt becomes 0. The FSM then goes to CAPTURE, or directly to DONE if the effective length is 1.
- In CAPTURE, dec_cnt increments every cycle. When dec_cnt==decim, the pair is written at address wr_count, wr_count increments and dec_cnt returns to 0.
- When a write brings wr_count to the effective length, the FSM goes to DONE and done=1.
- The effective length is cap_len, or DEPTH when cap_len=0. wr_count never exceeds DEPTH, and write addresses do not wrap.
- decim, cap_len and threshold are sampled at the trigger and held internally for the whole capture.
- abort in any state goes to IDLE and clears busy and done. wr_count keeps its value. abort wins over a simultaneous arm or trigger.
- A trigger on the same cycle as arm is not honoured. The trigger is only evaluated while already in ARMED.
- Reads are allowed in every state. If a read and a write hit the same address in the same cycle, rd_data returns the old contents (read-before-write).
- RAM contents are not reset.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, done=0, wr_count=0, state IDLE, s0/s1/prev_s0=0.
- Input-to-trigger latency is 1 cycle, because the pin is registered into s0.
- The sample written at address 0 is the s0/s1 value present in the trigger cycle.
- With decim=d, address k holds the sample k*(d+1) cycles after the trigger sample.
- done rises on the clock edge of the final write, and busy falls on the same edge.
- Read latency is 1 cycle: rd_en at cycle N gives rd_data/rd_valid at N+1. rd_valid is a 1-cycle pulse per rd_en. rd_data holds its value between reads.
- rst_n low mid-capture returns to IDLE on that edge and clears all outputs as listed above.

## Configuration
- ADC_CAPTURE_LEVEL_TRIG_EN defined: threshold and trig_sel are functional, and the level comparator and prev_s0 register are built.
- Not defined: only sw_trig triggers, and trig_sel/threshold are ignored. No comparator or prev_s0 logic is built.

## Test plan
- Software trigger with cap_len=4, decim=0, adc_ch0 ramp 0,1,2,…: done is asserted 3 cycles after the trigger edge; addresses 0–3 read back ch0 = t, t+1, t+2, t+3; wr_count=4.
- decim=2, cap_len=3, ramp input: the stored ch0 values differ by 3; done is asserted 6 cycles after the trigger.
- Macro defined, trig_sel=1, threshold=0x800, ch0 ramp 0x7FC upward: address 0 holds ch0=0x800. The same run with the macro undefined stays ARMED and busy=1.
- cap_len=0, decim=0: DEPTH writes, done asserts, wr_count=DEPTH; address DEPTH-1 holds the last sample.
- abort asserted 5 cycles into a cap_len=16 capture: IDLE next edge, busy=0, done=0, wr_count=5 or 6 per the write schedule. Asserting rst_n low mid-capture clears all outputs to their reset values.
- arm and sw_trig together: stays ARMED. A later sw_trig alone starts the capture.

Source files
------------

// File: rtl/adc_capture.sv
// Triggered capture buffer for the dual-channel ADC path: records decimated {ch1,ch0} pairs into RAM on a trigger.
// Optional level trigger on ch0 is built only when ADC_CAPTURE_LEVEL_TRIG_EN is defined.
module adc_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 12
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       adc_ch0,
  input  logic [DATA_W-1:0]       adc_ch1,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    sw_trig,
  input  logic                    trig_sel,
  input  logic [DATA_W-1:0]       threshold,
  input  logic [7:0]              decim,
  input  logic [DEPTH_LOG2-1:0]   cap_len,
  input  logic                    rd_en,
  input  logic [DEPTH_LOG2-1:0]   rd_addr,
  output logic [2*DATA_W-1:0]     rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic [DEPTH_LOG2:0]     wr_count
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [DATA_W-1:0]     s0_q, s1_q;
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      wr_count_q, wr_count_d, wr_count_inc;
  logic [7:0]            dec_cnt_q, dec_cnt_d;
  logic [7:0]            decim_q, decim_d;
  logic [CNT_W-1:0]      len_q, len_d, eff_len;
  logic                  we;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic                  level_hit;
  logic [2*DATA_W-1:0]   mem_q [DEPTH];
  logic [2*DATA_W-1:0]   rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= adc_ch0;
      s1_q <= adc_ch1;
    end
  end

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  logic [DATA_W-1:0] prev_s0_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) prev_s0_q <= '0;
    else        prev_s0_q <= s0_q;
  end

  // Unsigned rising crossing: previous sample below threshold, current at or above it.
  assign level_hit = trig_sel && (prev_s0_q < threshold) && (threshold <= s0_q);
`else
  logic unused_level;
  assign unused_level = ^{trig_sel, threshold};
  assign level_hit    = 1'b0;
`endif

  assign eff_len      = (cap_len == '0) ? DEPTH_C : {1'b0, cap_len};
  assign wr_count_inc = wr_count_q + ONE_C;

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    dec_cnt_d  = dec_cnt_q;
    decim_d    = decim_q;
    len_d      = len_q;
    we         = 1'b0;
    wr_addr    = '0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d    = S_ARMED;
            wr_count_d = '0;
          end
        end
        S_ARMED: begin
          if (sw_trig || level_hit) begin
            we         = 1'b1;
            wr_addr    = '0;
            wr_count_d = ONE_C;
            dec_cnt_d  = 8'd0;
            decim_d    = decim;
            len_d      = eff_len;
            state_d    = (eff_len == ONE_C) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (dec_cnt_q == decim_q) begin
            we         = 1'b1;
            wr_addr    = wr_count_q[DEPTH_LOG2-1:0];
            wr_count_d = wr_count_inc;
            dec_cnt_d  = 8'd0;
            if (wr_count_inc == len_q) state_d = S_DONE;
          end else begin
            dec_cnt_d = dec_cnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_count_q <= '0;
      dec_cnt_q  <= '0;
      decim_q    <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      dec_cnt_q  <= dec_cnt_d;
      decim_q    <= decim_d;
      len_q      <= len_d;
    end
  end

  // RAM is never reset; a read of the address being written returns the old word.
  always_ff @(posedge sys_clk) begin
    if (we && rst_n) mem_q[wr_addr] <= {s1_q, s0_q};
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: expected RAM contents come from a per-cycle sample history.
module tb_adc_capture;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [11:0]   adc_ch0 = '0, adc_ch1 = '0;
  logic          arm = 1'b0, abort = 1'b0, sw_trig = 1'b0, trig_sel = 1'b0;
  logic [11:0]   threshold = '0;
  logic [7:0]    decim = '0;
  logic [DL-1:0] cap_len = '0;
  logic          rd_en = 1'b0;
  logic [DL-1:0] rd_addr = '0;
  logic [23:0]   rd_data;
  logic          rd_valid, busy, done;
  logic [DL:0]   wr_count;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit ramp_mode = 1'b0;
  logic [11:0] ramp_val = '0;
  logic [11:0] h0 [int];
  logic [11:0] h1 [int];
  logic [23:0] mref [DEPTH];

  adc_capture #(.DEPTH_LOG2(DL), .DATA_W(12)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .adc_ch0(adc_ch0), .adc_ch1(adc_ch1),
    .arm(arm), .abort(abort), .sw_trig(sw_trig), .trig_sel(trig_sel),
    .threshold(threshold), .decim(decim), .cap_len(cap_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Tick n drives the sample seen at posedge n; outputs read after tick n reflect posedge n-1.
  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (ramp_mode) begin
      adc_ch0  = ramp_val;
      ramp_val = ramp_val + 12'd1;
    end else begin
      adc_ch0 = 12'($urandom);
    end
    adc_ch1 = 12'($urandom);
    h0[cyc] = adc_ch0;
    h1[cyc] = adc_ch1;
  endtask

  task automatic pulse_arm();
    tick(); arm = 1'b1;
    tick(); arm = 1'b0;
  endtask

  task automatic fire(output int tt);
    tick(); sw_trig = 1'b1; tt = cyc;
    tick(); sw_trig = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int e);
    e = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        e = cyc - 1;
        break;
      end
      tick();
    end
  endtask

  task automatic rd(input int a, output logic [23:0] d, output logic v);
    tick(); rd_en = 1'b1; rd_addr = DL'(a);
    tick(); rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  // Address k holds the registered sample of the trigger cycle plus k*(d+1) cycles.
  task automatic model_fill(input int tt, input int d, input int n);
    for (int k = 0; k < n; k++) begin
      mref[k] = {h1[tt - 1 + k*(d+1)], h0[tt - 1 + k*(d+1)]};
    end
  endtask

  task automatic do_capture(input int d, input int cl, output int tt, output int de);
    decim = 8'(d); cap_len = DL'(cl);
    pulse_arm();
    fire(tt);
    wait_done(DEPTH*(d+1) + 20, de);
    model_fill(tt, d, (cl == 0) ? DEPTH : cl);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rd_data, rd_valid, busy, done, wr_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd_data=%h rd_valid=%b busy=%b done=%b wr_count=%0d, want all zero",
               rd_data, rd_valid, busy, done, wr_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_sw_basic();
    int tt, de; logic [23:0] d; logic v;
    ramp_mode = 1'b1;
    do_capture(0, 4, tt, de);
    checks++;
    if (de !== tt + 3) begin errors++; $display("FAIL sw_done_edge: got %0d want %0d", de, tt + 3); end
    checks++;
    if (wr_count !== 11'd4 || busy !== 1'b0) begin
      errors++; $display("FAIL sw_wr_count: got %0d busy=%b want 4 busy=0", wr_count, busy);
    end
    for (int k = 0; k < 4; k++) begin
      rd(k, d, v);
      checks++;
      if (d !== mref[k] || v !== 1'b1 || d[11:0] !== h0[tt-1] + 12'(k)) begin
        errors++; $display("FAIL sw_read[%0d]: got %h v=%b want %h v=1", k, d, v, mref[k]);
      end
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== mref[3]) begin
      errors++; $display("FAIL rd_hold: got %h v=%b want %h v=0", rd_data, rd_valid, mref[3]);
    end
  endtask

  task automatic test_decim();
    int tt, de; logic [23:0] d; logic v;
    ramp_mode = 1'b1;
    do_capture(2, 3, tt, de);
    checks++;
    if (de !== tt + 6) begin errors++; $display("FAIL decim_done_edge: got %0d want %0d", de, tt + 6); end
    for (int k = 0; k < 3; k++) begin
      rd(k, d, v);
      checks++;
      if (d !== mref[k] || d[11:0] !== h0[tt-1] + 12'(3*k)) begin
        errors++; $display("FAIL decim_read[%0d]: got %h want %h", k, d, mref[k]);
      end
    end
  endtask

  task automatic test_level();
    int de; logic [23:0] d; logic v;
    ramp_mode = 1'b1; ramp_val = 12'h7F0;
    repeat (2) tick();
    trig_sel = 1'b1; threshold = 12'h800; cap_len = DL'(4); decim = 8'd0;
    pulse_arm();
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    wait_done(60, de);
    checks++;
    if (de < 0) begin errors++; $display("FAIL level_done: got timeout want done"); end
    for (int k = 0; k < 4; k++) begin
      rd(k, d, v);
      checks++;
      if (d[11:0] !== 12'h800 + 12'(k)) begin
        errors++; $display("FAIL level_read[%0d]: got ch0=%h want %h", k, d[11:0], 12'h800 + 12'(k));
      end
    end
`else
    repeat (40) tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || wr_count !== '0) begin
      errors++; $display("FAIL level_ignored: busy=%b done=%b wr_count=%0d want 1 0 0", busy, done, wr_count);
    end
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
`endif
    trig_sel = 1'b0;
  endtask

  task automatic test_full();
    int tt, de; logic [23:0] d; logic v; int a;
    ramp_mode = 1'b0;
    do_capture(0, 0, tt, de);
    checks++;
    if (de !== tt + DEPTH - 1) begin errors++; $display("FAIL full_done_edge: got %0d want %0d", de, tt + DEPTH - 1); end
    checks++;
    if (wr_count !== 11'(DEPTH)) begin errors++; $display("FAIL full_wr_count: got %0d want %0d", wr_count, DEPTH); end
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? DEPTH - 1 : (i == 1) ? 0 : $urandom_range(DEPTH - 1);
      rd(a, d, v);
      checks++;
      if (d !== mref[a]) begin errors++; $display("FAIL full_read[%0d]: got %h want %h", a, d, mref[a]); end
    end
  endtask

  task automatic test_back_to_back();
    int tt, de, dd, cl; logic [23:0] d; logic v;
    ramp_mode = 1'b0;
    for (int it = 0; it < 6; it++) begin
      dd = $urandom_range(3);
      cl = (it == 0) ? 1 : $urandom_range(12, 1);
      decim = 8'(dd); cap_len = DL'(cl);
      pulse_arm();
      checks++;
      if (done !== 1'b0 || wr_count !== '0 || busy !== 1'b1) begin
        errors++; $display("FAIL rearm[%0d]: done=%b wr_count=%0d busy=%b want 0 0 1", it, done, wr_count, busy);
      end
      fire(tt);
      wait_done(200, de);
      model_fill(tt, dd, cl);
      checks++;
      if (de !== tt + (cl - 1)*(dd + 1) || wr_count !== 11'(cl)) begin
        errors++; $display("FAIL b2b_done[%0d]: edge %0d cnt %0d want %0d cnt %0d",
                           it, de, wr_count, tt + (cl - 1)*(dd + 1), cl);
      end
      for (int k = 0; k < cl; k++) begin
        rd(k, d, v);
        checks++;
        if (d !== mref[k]) begin errors++; $display("FAIL b2b_read[%0d][%0d]: got %h want %h", it, k, d, mref[k]); end
      end
    end
  endtask

  task automatic test_rbw();
    int tt, de; logic [23:0] d, old_w; logic v;
    ramp_mode = 1'b0;
    do_capture(0, 8, tt, de);
    old_w = mref[3];
    pulse_arm();
    tick(); sw_trig = 1'b1; tt = cyc;
    tick(); sw_trig = 1'b0;
    tick();
    tick(); rd_en = 1'b1; rd_addr = DL'(3);
    tick(); rd_en = 1'b0;
    checks++;
    if (rd_data !== old_w) begin errors++; $display("FAIL rbw_old: got %h want %h", rd_data, old_w); end
    wait_done(40, de);
    model_fill(tt, 0, 8);
    rd(3, d, v);
    checks++;
    if (d !== mref[3]) begin errors++; $display("FAIL rbw_new: got %h want %h", d, mref[3]); end
  endtask

  task automatic test_abort();
    int tt, ab, expw; logic [23:0] d; logic v;
    ramp_mode = 1'b0;
    decim = 8'd0; cap_len = DL'(16);
    pulse_arm();
    fire(tt);
    while (cyc < tt + 4) tick();
    tick(); abort = 1'b1; ab = cyc;
    tick(); abort = 1'b0;
    expw = (ab - 1 - tt) + 1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_count !== 11'(expw)) begin
      errors++; $display("FAIL abort_state: busy=%b done=%b wr_count=%0d want 0 0 %0d", busy, done, wr_count, expw);
    end
    repeat (5) tick();
    checks++;
    if (wr_count !== 11'(expw) || busy !== 1'b0) begin
      errors++; $display("FAIL abort_hold: wr_count=%0d busy=%b want %0d 0", wr_count, busy, expw);
    end
    model_fill(tt, 0, expw);
    rd(expw - 1, d, v);
    checks++;
    if (d !== mref[expw - 1]) begin errors++; $display("FAIL abort_read: got %h want %h", d, mref[expw - 1]); end

    pulse_arm();
    checks++;
    if (wr_count !== '0) begin errors++; $display("FAIL arm_clear: wr_count=%0d want 0", wr_count); end
    tick(); sw_trig = 1'b1; abort = 1'b1;
    tick(); sw_trig = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || wr_count !== '0) begin
      errors++; $display("FAIL abort_vs_trig: busy=%b wr_count=%0d want 0 0", busy, wr_count);
    end

    pulse_arm();
    fire(tt);
    rd(0, d, v);
    tick(); rst_n = 1'b0; rd_en = 1'b1; rd_addr = '0;
    tick(); rst_n = 1'b1; rd_en = 1'b0;
    checks++;
    if ({rd_data, rd_valid, busy, done, wr_count} !== '0) begin
      errors++;
      $display("FAIL midcap_reset: rd_data=%h rd_valid=%b busy=%b done=%b wr_count=%0d want all zero",
               rd_data, rd_valid, busy, done, wr_count);
    end
  endtask

  task automatic test_arm_trig();
    int tt, de; logic [23:0] d; logic v;
    ramp_mode = 1'b0;
    decim = 8'd1; cap_len = DL'(2);
    tick(); arm = 1'b1; sw_trig = 1'b1;
    tick(); arm = 1'b0; sw_trig = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || wr_count !== '0) begin
      errors++; $display("FAIL arm_trig_same: busy=%b done=%b wr_count=%0d want 1 0 0", busy, done, wr_count);
    end
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1 || wr_count !== '0) begin
      errors++; $display("FAIL arm_trig_wait: busy=%b wr_count=%0d want 1 0", busy, wr_count);
    end
    fire(tt);
    wait_done(20, de);
    model_fill(tt, 1, 2);
    checks++;
    if (de !== tt + 2) begin errors++; $display("FAIL late_trig_done: got %0d want %0d", de, tt + 2); end
    for (int k = 0; k < 2; k++) begin
      rd(k, d, v);
      checks++;
      if (d !== mref[k]) begin errors++; $display("FAIL late_trig_read[%0d]: got %h want %h", k, d, mref[k]); end
    end
  endtask

  initial begin
    h0[0] = '0;
    h1[0] = '0;
    test_reset();
    test_sw_basic();
    test_decim();
    test_level();
    test_full();
    test_back_to_back();
    test_rbw();
    test_abort();
    test_arm_trig();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
